// File: rtl/sat_addsub_arbiter.sv
// Two-requester round-robin front end sharing one 16-bit signed saturating add/subtract
// unit, with a single-entry result register drained by a valid/ready handshake.
module sat_addsub_arbiter #(
  parameter bit PRIO_INIT = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic             req1_sub,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [15:0]      resp_sum,
  output logic             resp_ovfl,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q;
  logic             prio_q;
  logic             id_q;
  logic [15:0]      sum_q;
  logic             ovfl_q;
  logic [CNT_W-1:0] count_q;

  logic        can_accept;
  logic        grant0;
  logic        grant1;
  logic        drain;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic        sel_sub;
  logic [16:0] op_d;

  // Returns {ovfl, result}; overflow clamps toward the sign of operand A.
  function automatic logic [16:0] sat_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic sub);
    logic [15:0] b_eff;
    logic [15:0] s;
    logic        ovfl;
    b_eff = sub ? ~b : b;
    s     = a + b_eff + {15'd0, sub};
    ovfl  = (sub ? (a[15] != b[15]) : (a[15] == b[15])) && (s[15] != a[15]);
    if (ovfl) return {1'b1, (a[15] ? 16'h8000 : 16'h7FFF)};
    return {1'b0, s};
  endfunction

  assign drain      = (state_q == FULL) && resp_ready;
  // Gating with rst_n keeps both readys low for the whole time reset is held.
  assign can_accept = rst_n && ((state_q == EMPTY) || resp_ready);
  assign grant0     = can_accept && req0_valid && (!req1_valid || (prio_q == 1'b0));
  assign grant1     = can_accept && req1_valid && (!req0_valid || (prio_q == 1'b1));

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_a   = grant1 ? req1_a   : req0_a;
  assign sel_b   = grant1 ? req1_b   : req0_b;
  assign sel_sub = grant1 ? req1_sub : req0_sub;
  assign op_d    = sat_op(sel_a, sel_b, sel_sub);

  // NOTE: every register here uses <= so all updates see pre-edge values; mixing in
  // blocking assignments would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      prio_q  <= PRIO_INIT;
      id_q    <= 1'b0;
      sum_q   <= 16'h0000;
      ovfl_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (drain) count_q <= count_q + CNT_W'(1);
      if (grant0 || grant1) begin
        state_q <= FULL;
        prio_q  <= grant0;
        id_q    <= grant1;
        sum_q   <= op_d[15:0];
        ovfl_q  <= op_d[16];
      end else if (drain) begin
        state_q <= EMPTY;
      end
    end
  end

  assign resp_valid = (state_q == FULL);
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign resp_ovfl  = ovfl_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_sat_addsub_arbiter.sv
// Self-checking bench: directed scenarios plus constrained-random traffic, all
// compared against an integer-arithmetic transaction model of the block.
module tb_sat_addsub_arbiter;

  localparam int  CNT_W = 4;
  localparam bit  PRIO  = 1'b0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid, req0_sub, req1_sub;
  logic             req0_ready, req1_ready;
  logic [15:0]      req0_a, req0_b, req1_a, req1_b;
  logic             resp_valid, resp_ready, resp_id, resp_ovfl;
  logic [15:0]      resp_sum;
  logic [CNT_W-1:0] op_count;

  sat_addsub_arbiter #(.PRIO_INIT(PRIO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_sub(req1_sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_ovfl(resp_ovfl), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model state.
  bit      m_valid;
  bit      m_id;
  bit [15:0] m_sum;
  bit      m_ovfl;
  int      m_cnt;
  bit      m_prio;
  bit      last_g0, last_g1;

  function automatic bit [16:0] ref_op(input bit [15:0] a, input bit [15:0] b, input bit sub);
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r  = sub ? sa - sb : sa + sb;
    if (r > 32767)  return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  // One clock: check grants before the edge, advance the model, check outputs after it.
  task automatic tick();
    bit can, g0, g1;
    bit [16:0] r;
    @(negedge clk);
    can = rst_n && (!m_valid || resp_ready);
    g0  = can && req0_valid && (!req1_valid || m_prio == 1'b0);
    g1  = can && req1_valid && (!req0_valid || m_prio == 1'b1);
    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));
    last_g0 = g0;
    last_g1 = g1;
    if (!rst_n) begin
      m_valid = 0; m_id = 0; m_sum = 0; m_ovfl = 0; m_cnt = 0; m_prio = PRIO;
    end else begin
      if (m_valid && resp_ready) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (g0 || g1) begin
        r = g1 ? ref_op(req1_a, req1_b, req1_sub) : ref_op(req0_a, req0_b, req0_sub);
        m_valid = 1; m_id = g1; m_sum = r[15:0]; m_ovfl = r[16];
        m_prio = g0 ? 1'b1 : 1'b0;
      end else if (m_valid && resp_ready) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    check("resp_valid", 32'(resp_valid), 32'(m_valid));
    check("op_count", 32'(op_count), 32'(m_cnt));
    if (m_valid) begin
      check("resp_id", 32'(resp_id), 32'(m_id));
      check("resp_sum", 32'(resp_sum), 32'(m_sum));
      check("resp_ovfl", 32'(resp_ovfl), 32'(m_ovfl));
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_sub = 0; req1_sub = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic drive0(input bit [15:0] a, input bit [15:0] b, input bit sub);
    req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub;
  endtask

  logic [15:0] sat_a [4] = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
  logic [15:0] sat_b [4] = '{16'h0001, 16'h0001, 16'h8000, 16'hFFFF};
  logic        sat_s [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [15:0] sat_r [4] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFE};
  logic        sat_o [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [15:0] held_sum;
    idle_inputs();
    resp_ready = 1;
    m_prio = PRIO;
    do_reset();
    check("rst_sum", 32'(resp_sum), 32'h0);
    check("rst_id", 32'(resp_id), 32'h0);
    check("rst_ovfl", 32'(resp_ovfl), 32'h0);

    // Idle, then a simple add.
    tick();
    check("idle_valid", 32'(resp_valid), 32'h0);
    drive0(16'd5, 16'd3, 1'b0);
    tick();
    check("add_sum", 32'(resp_sum), 32'h0008);
    check("add_id", 32'(resp_id), 32'h0);
    idle_inputs();
    tick();
    check("add_count", 32'(op_count), 32'h1);

    // Saturation corners.
    for (int i = 0; i < 4; i++) begin
      drive0(sat_a[i], sat_b[i], sat_s[i]);
      tick();
      check("sat_sum", 32'(resp_sum), 32'(sat_r[i]));
      check("sat_ovfl", 32'(resp_ovfl), 32'(sat_o[i]));
    end
    idle_inputs();
    tick();

    // Contention: both valid every cycle, grants must alternate from PRIO.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive0(16'($urandom), 16'($urandom), 1'($urandom));
      req1_valid = 1; req1_a = 16'($urandom); req1_b = 16'($urandom); req1_sub = 1'($urandom);
      tick();
      check("rr_id", 32'(resp_id), 32'((i + int'(PRIO)) % 2));
    end
    idle_inputs();
    tick();

    // Backpressure: hold a result, then drain and refill with requester 1.
    resp_ready = 0;
    drive0(16'h1234, 16'h0101, 1'b0);
    tick();
    held_sum = 16'h1335;
    check("bp_load", 32'(resp_sum), 32'(held_sum));
    req1_valid = 1; req1_a = 16'h0010; req1_b = 16'h0001; req1_sub = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold", 32'(resp_sum), 32'(held_sum));
    end
    req0_valid = 0;
    resp_ready = 1;
    tick();
    check("bp_refill_id", 32'(resp_id), 32'h1);
    check("bp_refill_sum", 32'(resp_sum), 32'h000F);
    idle_inputs();
    tick();

    // Reset mid-flight after a requester-0 grant moved the pointer away from PRIO.
    resp_ready = 0;
    drive0(16'h0100, 16'h0001, 1'b0);
    tick();
    idle_inputs();
    rst_n = 0;
    tick();
    check("mid_rst_valid", 32'(resp_valid), 32'h0);
    check("mid_rst_count", 32'(op_count), 32'h0);
    rst_n = 1;
    resp_ready = 1;
    drive0(16'h0001, 16'h0001, 1'b0);
    req1_valid = 1; req1_a = 16'h0002; req1_b = 16'h0002; req1_sub = 0;
    tick();
    check("post_rst_winner", 32'(resp_id), 32'(PRIO));
    idle_inputs();
    tick();

    // Counter wrap: 17 deliveries on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive0(16'(i), 16'd1, 1'b0);
      tick();
    end
    idle_inputs();
    tick();
    check("wrap_count", 32'(op_count), 32'h1);

    // Random traffic; a requester holds its operation until granted or it drops it.
    for (int i = 0; i < 400; i++) begin
      resp_ready = ($urandom_range(3) != 0);
      rst_n = ($urandom_range(63) != 0);
      if (!req0_valid || last_g0 || $urandom_range(7) == 0)
        drive0(16'($urandom), 16'($urandom), 1'($urandom));
      if (!req0_valid || last_g0) req0_valid = 1'($urandom);
      if (!req1_valid || last_g1 || $urandom_range(7) == 0) begin
        req1_a = 16'($urandom); req1_b = 16'($urandom); req1_sub = 1'($urandom);
        req1_valid = 1'($urandom);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sat_addsub_arbiter.md
Name: sat_addsub_arbiter

Overview:
- Shares one 16-bit signed saturating add/subtract datapath between two requesters (e.g. the ALU issue path and the address/reduction sequencer).
- Accepts at most one operation per cycle using round-robin arbitration.
- Computes the operation and holds the saturated result and overflow flag in a single-entry output register.
- The output register drains through a valid/ready handshake, tagged with the winning requester's ID.

Parameters:
- PRIO_INIT, 0, requester that holds round-robin priority after reset (0 or 1).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  16  requester 0 operand A, signed.
- req0_b  input  16  requester 0 operand B, signed.
- req0_sub  input  1  requester 0 operation select: 1 = A-B, 0 = A+B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as requester 0, for requester 1.
- resp_valid  output  1  result register holds an undelivered result.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  1  requester that issued the held result.
- resp_sum  output  16  saturated result.
- resp_ovfl  output  1  signed overflow occurred; resp_sum is saturated.
- op_count  output  CNT_W  number of results delivered since reset.

Behaviour:
- Reset (rst_n low at a clock edge):
  - resp_valid=0, resp_id=0, resp_sum=16'h0000, resp_ovfl=0, op_count=0.
  - Priority pointer = PRIO_INIT.
  - Any in-flight result is discarded.
  - reqX_ready=0 while rst_n is low.
- State machine, two states:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
- can_accept = EMPTY, or (FULL and resp_ready). A same-cycle drain and refill gives full throughput of one operation per cycle.
- Grant (combinational, only when can_accept):
  - Only one requester valid: that requester wins.
  - Both valid: the requester named by the priority pointer wins.
  - reqX_ready = grant to X. The loser's ready stays 0, and it must hold its valid and operands stable.
- On a grant:
  - The priority pointer moves to the other requester (the loser).
  - If there is no grant, the pointer is unchanged.
- Latency: an operation accepted in cycle N appears on resp_* in cycle N+1.
  - resp_* stay stable while resp_valid=1 and resp_ready=0.
- State transitions:
  - EMPTY + grant -> FULL.
  - FULL + resp_ready + no grant -> EMPTY.
  - FULL + resp_ready + grant -> FULL, with new contents loaded.
  - FULL + !resp_ready -> FULL, contents held.
- op_count increments by 1 on each cycle where resp_valid and resp_ready are both 1. It wraps modulo 2^CNT_W.
- Arithmetic, 16-bit two's complement:
  - B' = sub ? ~B : B; raw S = A + B' + sub.
  - Add: ovfl = (A[15]==B[15]) and (S[15]!=A[15]).
  - Sub: ovfl = (A[15]!=B[15]) and (S[15]!=A[15]).
  - Saturation: ovfl and A[15]=1 gives 16'h8000; ovfl and A[15]=0 gives 16'h7FFF; otherwise S.
  - Carry out of bit 15 is discarded.
- Boundary cases:
  - resp_ready asserted while EMPTY: ignored, op_count unchanged.
  - A requester may drop valid before it is granted; no result is produced for it.
  - Reset mid-operation takes priority over every other event in the same cycle.

Test Plan:
- Reset, then idle: resp_valid=0 and op_count=0. Then req0 5+3 with resp_ready=1 -> next cycle resp_valid=1, resp_id=0, resp_sum=16'h0008, resp_ovfl=0; op_count=1 after the handshake.
- Saturation: 16'h7FFF+16'h0001 -> 16'h7FFF, ovfl=1. 16'h8000-16'h0001 -> 16'h8000, ovfl=1. 16'h0000-16'h8000 -> 16'h7FFF, ovfl=1. 16'hFFFF+16'hFFFF -> 16'hFFFE, ovfl=0.
- Contention with PRIO_INIT=0, both requesters valid every cycle, resp_ready=1:
  - Grants alternate 0,1,0,1.
  - One resp per cycle, resp_id alternating.
  - No requester is granted twice in a row.
- Backpressure:
  - Load one result, then hold resp_ready=0 for 3 cycles: req ready=0 and resp_* stable.
  - Raise resp_ready with req1 valid: drain and refill in the same cycle, and resp_id=1 on the next cycle.
- Reset mid-flight: rst_n low with resp_valid=1 -> next edge resp_valid=0, op_count=0, pointer=PRIO_INIT; the first contention after reset is won by PRIO_INIT.
- Wrap: with CNT_W=4, deliver 17 results -> op_count=1.
